axi_lite_mem_responder: RTL
===========================

// Module: axi_lite_mem_responder
// PURPOSE
//  AXI4-Lite responder (slave end) fronting an on-chip word memory.
//  Terminates the master port of the address adaptor: serves core/peripheral
//  reads and writes at fixed latency. Has independent read and write engines
//  with byte strobes, range checking and an optional byte-swap.
// PARAMETERS
//  ADDR_WIDTH     16  width of s_araddr/s_awaddr (matches adaptor DEST_WIDTH)
//  BASE           0   byte address mapped to word 0
//  DEPTH_WORDS    1024  memory depth in 32-bit words (power of two)
//  CHANGE_ENDIAN  0   1: byte-reverse wdata, wstrb lanes and rdata
// PORTS
//  clk        in   1   clock, all logic on posedge
//  rst        in   1   synchronous active-high reset
//  s_araddr   in   ADDR_WIDTH  read byte address
//  s_arprot   in   3   ignored
//  s_arvalid  in   1   read address valid
//  s_arready  out  1   read address ready
//  s_rdata    out  32  read data
//  s_rresp    out  2   read response (00 OKAY, 10 SLVERR)
//  s_rvalid   out  1   read data valid
//  s_rready   in   1   read data ready
//  s_awaddr   in   ADDR_WIDTH  write byte address
//  s_awprot   in   3   ignored
//  s_awvalid  in   1   write address valid
//  s_awready  out  1   write address ready
//  s_wdata    in   32  write data
//  s_wstrb    in   4   byte enables, bit i = wdata[8i+7:8i]
//  s_wvalid   in   1   write data valid
//  s_wready   out  1   write data ready
//  s_bresp    out  2   write response (00 OKAY, 10 SLVERR)
//  s_bvalid   out  1   write response valid
//  s_bready   in   1   write response ready
// BEHAVIOUR
//  Reset (rst=1 at posedge): arready=awready=wready=1; rvalid=bvalid=0;
//   rdata=0; rresp=bresp=00; both FSMs to IDLE; in-flight transactions
//   dropped; memory contents NOT cleared. Reset mid-transfer is legal.
//  Address: off=addr-BASE (ADDR_WIDTH-bit wrap); idx=off[..:2]; addr[1:0]
//   ignored. In range iff addr>=BASE and off<DEPTH_WORDS*4.
//  Read FSM: R_IDLE(arready=1) -AR hs @T-> R_MEM(arready=0, mem read issued)
//   -> R_RESP(rvalid=1 from T+2, rdata/rresp stable) -R hs-> R_IDLE.
//   arready returns 1 the cycle after the R handshake; one read outstanding.
//   Out of range: rresp=10, rdata=0, memory not read.
//  Write FSM: W_IDLE: AW and W accepted independently; each ready drops
//   after its handshake and its payload is latched; may arrive same cycle
//   or in either order. Both latched (last hs @T) -> W_EXEC @T+1: memory
//   byte-write per strobe (wstrb=0: no change, OKAY) -> W_RESP: bvalid=1
//   from T+2 until B hs; awready=wready=1 the cycle after B hs.
//   Out of range: no write, bresp=10.
//  CHANGE_ENDIAN=1: wdata bytes reversed and wstrb[3:0] reversed before
//   write; rdata bytes reversed on output.
//  Collision: R_MEM and W_EXEC same word same cycle -> read returns OLD data
//   (read-first); write still completes.
//  rvalid/bvalid never drop without handshake; outputs do not depend
//   combinationally on inputs.
// TESTING
//  1 reset, W addr=BASE+8 data=DEADBEEF strb=F, R addr=BASE+8 -> bresp=00,
//    rdata=DEADBEEF rresp=00; rvalid exactly 2 cycles after AR hs.
//  2 W DEADBEEF then W addr=BASE+8 data=00112233 strb=0101 -> read returns
//    DE11BE33; W before AW by 3 cycles -> same result, bvalid 2 cyc after AW.
//  3 R/W addr=BASE+DEPTH_WORDS*4 and addr=BASE-4 (BASE>0) -> resp=10,
//    rdata=0, adjacent last word unchanged.
//  4 hold rready=0/bready=0 10 cycles -> rvalid/bvalid/data stable,
//    arready/awready/wready stay 0; random ready backpressure soak vs model.
//  5 CHANGE_ENDIAN=1: write 01020304 strb=0001 to zeroed word -> raw mem
//    04000000, read back 00000004... i.e. rdata=00000004 after swap.
//  6 rst asserted in R_RESP and W_EXEC -> next cycle rvalid=bvalid=0, all
//    readies=1; earlier-written words still read back intact.

Source files
------------

// File: rtl/axi_lite_mem_responder_if.sv
// AXI4-Lite bus bundle between a master and the memory responder.
// The slave modport is the responder's view; master is the requester's view.
interface axi_lite_mem_responder_if #(
    parameter int ADDR_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    logic [31:0]           rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    modport slave (
        input  araddr, arprot, arvalid, rready,
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid,
        output awready, wready, bresp, bvalid
    );

    modport master (
        output araddr, arprot, arvalid, rready,
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid,
        input  awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/axi_lite_mem_responder.sv
// AXI4-Lite slave over a 32-bit word memory: independent fixed-latency read and
// write engines, byte strobes, range checking and optional byte reversal.
module axi_lite_mem_responder #(
    parameter int                    ADDR_WIDTH    = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE          = '0,
    parameter int                    DEPTH_WORDS   = 1024,
    parameter bit                    CHANGE_ENDIAN = 1'b0
) (
    input logic                     clk,
    input logic                     rst,
    axi_lite_mem_responder_if.slave s
);
    localparam int          IDX_W       = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN        = 32'(DEPTH_WORDS) * 32'd4;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {R_IDLE, R_MEM, R_RESP} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} w_state_e;

    function automatic logic [31:0] swap_bytes(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    logic [31:0] mem_q [DEPTH_WORDS];

    // A borrow out of the subtraction means the address sits below BASE.
    logic [ADDR_WIDTH-1:0] ar_off, aw_off;
    logic                  ar_borrow, aw_borrow, ar_ok, aw_ok;
    assign {ar_borrow, ar_off} = {1'b0, s.araddr} - {1'b0, BASE};
    assign {aw_borrow, aw_off} = {1'b0, s.awaddr} - {1'b0, BASE};
    assign ar_ok = !ar_borrow && (32'(ar_off) < SPAN);
    assign aw_ok = !aw_borrow && (32'(aw_off) < SPAN);

    r_state_e           r_state_q, r_state_d;
    logic [IDX_W-1:0]   ar_idx_q, ar_idx_d;
    logic               ar_ok_q, ar_ok_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [1:0]         rresp_q, rresp_d;
    logic [31:0]        rd_word;

    w_state_e           w_state_q, w_state_d;
    logic               aw_held_q, aw_held_d;
    logic               w_held_q, w_held_d;
    logic [IDX_W-1:0]   aw_idx_q, aw_idx_d;
    logic               aw_ok_q, aw_ok_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [3:0]         wstrb_q, wstrb_d;
    logic [1:0]         bresp_q, bresp_d;

    logic               mem_we;
    logic [31:0]        mem_wdata;
    logic [3:0]         mem_wstrb;

    assign rd_word = mem_q[ar_idx_q];

    // NOTE: every _d starts as its _q so no path leaves it unassigned (no latch).
    always_comb begin
        r_state_d = r_state_q;
        ar_idx_d  = ar_idx_q;
        ar_ok_d   = ar_ok_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        unique case (r_state_q)
            R_IDLE: begin
                if (s.arvalid) begin
                    ar_idx_d  = ar_off[IDX_W+1:2];
                    ar_ok_d   = ar_ok;
                    r_state_d = R_MEM;
                end
            end
            R_MEM: begin
                rdata_d   = ar_ok_q ? (CHANGE_ENDIAN ? swap_bytes(rd_word) : rd_word) : '0;
                rresp_d   = ar_ok_q ? RESP_OKAY : RESP_SLVERR;
                r_state_d = R_RESP;
            end
            R_RESP: begin
                if (s.rready) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        w_state_d = w_state_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        aw_idx_d  = aw_idx_q;
        aw_ok_d   = aw_ok_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bresp_d   = bresp_q;
        unique case (w_state_q)
            W_IDLE: begin
                if (s.awvalid && !aw_held_q) begin
                    aw_held_d = 1'b1;
                    aw_idx_d  = aw_off[IDX_W+1:2];
                    aw_ok_d   = aw_ok;
                end
                if (s.wvalid && !w_held_q) begin
                    w_held_d = 1'b1;
                    wdata_d  = s.wdata;
                    wstrb_d  = s.wstrb;
                end
                if (aw_held_d && w_held_d) w_state_d = W_EXEC;
            end
            W_EXEC: begin
                aw_held_d = 1'b0;
                w_held_d  = 1'b0;
                bresp_d   = aw_ok_q ? RESP_OKAY : RESP_SLVERR;
                w_state_d = W_RESP;
            end
            W_RESP: begin
                if (s.bready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    assign mem_we    = (w_state_q == W_EXEC) && aw_ok_q;
    assign mem_wdata = CHANGE_ENDIAN ? swap_bytes(wdata_q) : wdata_q;
    assign mem_wstrb = CHANGE_ENDIAN ? {wstrb_q[0], wstrb_q[1], wstrb_q[2], wstrb_q[3]} : wstrb_q;

    // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            ar_idx_q  <= '0;
            ar_ok_q   <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            w_state_q <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            aw_idx_q  <= '0;
            aw_ok_q   <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bresp_q   <= RESP_OKAY;
        end else begin
            r_state_q <= r_state_d;
            ar_idx_q  <= ar_idx_d;
            ar_ok_q   <= ar_ok_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            w_state_q <= w_state_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            aw_idx_q  <= aw_idx_d;
            aw_ok_q   <= aw_ok_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bresp_q   <= bresp_d;
        end
    end

    // NOTE: the memory array is deliberately not reset; reset only drops an in-flight write.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_wstrb[b]) mem_q[aw_idx_q][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    assign s.arready = (r_state_q == R_IDLE);
    assign s.rvalid  = (r_state_q == R_RESP);
    assign s.rdata   = rdata_q;
    assign s.rresp   = rresp_q;
    assign s.awready = (w_state_q == W_IDLE) && !aw_held_q;
    assign s.wready  = (w_state_q == W_IDLE) && !w_held_q;
    assign s.bvalid  = (w_state_q == W_RESP);
    assign s.bresp   = bresp_q;

    logic unused_ok;
    assign unused_ok = ^{s.arprot, s.awprot, ar_off[1:0], aw_off[1:0]};
endmodule
